// File: rtl/ppu_framebuffer_pkg.sv
// Shared PPU types and constants: LCD geometry, pixel shade, framebuffer
// writer states and the PPU mode encoding.
package ppu_pkg;

  localparam int LCD_WIDTH  = 160;
  localparam int LCD_HEIGHT = 144;

  typedef logic [1:0] shade_t;

  typedef enum logic [1:0] {
    FbDraw,
    FbLineEnd,
    FbFrameEnd
  } fb_wr_state_e;

  typedef enum logic [1:0] {
    ModeHBlank  = 2'd0,
    ModeVBlank  = 2'd1,
    ModeOamScan = 2'd2,
    ModeDraw    = 2'd3
  } ppu_mode_e;

endpackage

// File: rtl/ppu_framebuffer_bank_ram.sv
// One frame-store bank: simple dual-port RAM with synchronous write and a
// registered read that holds its output while rd_en is low.
module fb_bank_ram
  import ppu_pkg::*;
#(
  parameter int DEPTH  = LCD_WIDTH * LCD_HEIGHT,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  shade_t            wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output shade_t            rd_data
);

  shade_t mem [DEPTH];
  shade_t rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ppu_framebuffer.sv
// Double-buffered 160x144 frame store fed by the PPU pixel stream; banks swap
// only when a complete frame has been written, so the scanner never sees tearing.
module ppu_framebuffer
  import ppu_pkg::*;
#(
  parameter int WIDTH  = LCD_WIDTH,
  parameter int HEIGHT = LCD_HEIGHT,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lcd_enable,
  input  logic [1:0]        pixel_in,
  input  logic              pixel_valid,
  input  logic              ppu_hblank,
  input  logic              ppu_vblank,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_enable,
  output logic [1:0]        rd_data,
  output logic              frame_done,
  output logic              front_bank,
  output logic              overflow
);

  localparam int XW    = $clog2(WIDTH + 1);
  localparam int YW    = $clog2(HEIGHT + 1);
  localparam int DEPTH = WIDTH * HEIGHT;

  fb_wr_state_e      state_q, state_d;
  logic [XW-1:0]     wr_x_q, wr_x_d;
  logic [YW-1:0]     wr_y_q, wr_y_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic              front_q, front_d;
  logic              blank_q, blank_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;
  logic              rd_sel_q, rd_sel_d;
  logic              rd_oor_q, rd_oor_d;
  logic              hb_q, vb_q, lcd_q;
  logic              hb_rise, vb_rise, accept;
  shade_t            bank_rd [2];

  assign hb_rise = ppu_hblank & ~hb_q;
  assign vb_rise = ppu_vblank & ~vb_q;
  assign accept  = (state_q == FbDraw) && pixel_valid && lcd_enable &&
                   (wr_x_q < XW'(WIDTH)) && (wr_y_q < YW'(HEIGHT));

  always_comb begin
    state_d      = state_q;
    wr_x_d       = wr_x_q;
    wr_y_d       = wr_y_q;
    wr_addr_d    = wr_addr_q;
    line_base_d  = line_base_q;
    front_d      = front_q;
    blank_d      = blank_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    rd_sel_d     = rd_sel_q;
    rd_oor_d     = rd_oor_q;

    // Bank select and range are captured with the read so a read in the swap
    // cycle still returns the old front bank.
    if (rd_enable) begin
      rd_sel_d = front_q;
      rd_oor_d = (rd_addr >= ADDR_W'(DEPTH));
    end

    if (pixel_valid && lcd_enable && !accept) overflow_d = 1'b1;
    if (accept) begin
      wr_x_d    = wr_x_q + 1'b1;
      wr_addr_d = wr_addr_q + 1'b1;
    end

    if (!lcd_enable) begin
      wr_x_d      = '0;
      wr_y_d      = '0;
      wr_addr_d   = '0;
      line_base_d = '0;
      state_d     = FbFrameEnd;
      blank_d     = 1'b1;
      if (lcd_q) overflow_d = 1'b0;
    end else begin
      case (state_q)
        FbDraw: begin
          // Line end sees the post-accept wr_x; an empty line does not advance y.
          if (hb_rise) begin
            if (wr_x_d != '0) begin
              wr_y_d      = wr_y_q + 1'b1;
              wr_addr_d   = line_base_q + ADDR_W'(WIDTH);
              line_base_d = line_base_q + ADDR_W'(WIDTH);
            end
            wr_x_d  = '0;
            state_d = FbLineEnd;
          end
        end
        FbLineEnd:  if (!ppu_hblank) state_d = FbDraw;
        FbFrameEnd: if (!ppu_vblank) state_d = FbDraw;
        default:    state_d = FbDraw;
      endcase

      // Frame end overrides line end but counts a line that completed this cycle.
      if (vb_rise) begin
        if (wr_y_d == YW'(HEIGHT)) begin
          front_d      = ~front_q;
          frame_done_d = 1'b1;
          blank_d      = 1'b0;
        end
        wr_x_d      = '0;
        wr_y_d      = '0;
        wr_addr_d   = '0;
        line_base_d = '0;
        state_d     = FbFrameEnd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FbDraw;
      wr_x_q       <= '0;
      wr_y_q       <= '0;
      wr_addr_q    <= '0;
      line_base_q  <= '0;
      front_q      <= 1'b0;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      rd_sel_q     <= 1'b0;
      rd_oor_q     <= 1'b0;
      hb_q         <= 1'b0;
      vb_q         <= 1'b0;
      lcd_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_x_q       <= wr_x_d;
      wr_y_q       <= wr_y_d;
      wr_addr_q    <= wr_addr_d;
      line_base_q  <= line_base_d;
      front_q      <= front_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      rd_sel_q     <= rd_sel_d;
      rd_oor_q     <= rd_oor_d;
      hb_q         <= ppu_hblank;
      vb_q         <= ppu_vblank;
      lcd_q        <= lcd_enable;
    end
  end

  // The writer always targets the back bank, the reader the front bank.
  for (genvar i = 0; i < 2; i++) begin : g_bank
    fb_bank_ram #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
    ) u_ram (
      .clk    (clk),
      .wr_en  (accept && (front_q != 1'(i))),
      .wr_addr(wr_addr_q),
      .wr_data(pixel_in),
      .rd_en  (rd_enable),
      .rd_addr(rd_addr),
      .rd_data(bank_rd[i])
    );
  end

  assign rd_data    = (blank_q || rd_oor_q) ? 2'b00 : bank_rd[rd_sel_q];
  assign frame_done = frame_done_q;
  assign front_bank = front_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ppu_framebuffer.sv
// Scenario bench for ppu_framebuffer: random and patterned frames compared
// against a frame-level model of the displayed picture.
module tb_ppu_framebuffer;
  import ppu_pkg::*;

  localparam int W = 160;
  localparam int H = 144;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lcd_enable = 1'b1;
  logic [1:0]  pixel_in = '0;
  logic        pixel_valid = 1'b0;
  logic        ppu_hblank = 1'b0;
  logic        ppu_vblank = 1'b0;
  logic [14:0] rd_addr = '0;
  logic        rd_enable = 1'b0;
  logic [1:0]  rd_data;
  logic        frame_done, front_bank, overflow;

  always #5 clk = ~clk;

  ppu_framebuffer dut (
    .clk        (clk),
    .reset      (reset),
    .lcd_enable (lcd_enable),
    .pixel_in   (pixel_in),
    .pixel_valid(pixel_valid),
    .ppu_hblank (ppu_hblank),
    .ppu_vblank (ppu_vblank),
    .rd_addr    (rd_addr),
    .rd_enable  (rd_enable),
    .rd_data    (rd_data),
    .frame_done (frame_done),
    .front_bank (front_bank),
    .overflow   (overflow)
  );

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;

  // Model: picture being built, picture on display, and display flags.
  bit [1:0] build [N];
  bit [1:0] disp  [N];
  int       mdl_y = 0;
  bit       mdl_blank = 1'b1;
  bit       mdl_front = 1'b0;
  bit       mdl_ovf = 1'b0;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit [1:0] exp_rd(input int a);
    return (mdl_blank || a >= N) ? 2'b00 : disp[a];
  endfunction

  task automatic do_read(input int a, output logic [1:0] d);
    rd_addr   = 15'(a);
    rd_enable = 1'b1;
    tick();
    rd_enable = 1'b0;
    d = rd_data;
  endtask

  // Sends n pixels; the last one shares its cycle with the hblank rise.
  task automatic send_line(input int n, input bit rnd);
    bit [1:0] s;
    for (int x = 0; x < n; x++) begin
      s = rnd ? 2'($urandom) : ((x < W) ? 2'(x) : ~2'(x));
      pixel_valid = 1'b1;
      pixel_in    = s;
      ppu_hblank  = (x == n - 1);
      if (x < W && mdl_y < H) build[mdl_y * W + x] = s;
      else mdl_ovf = 1'b1;
      tick();
    end
    if (n == 0) begin
      ppu_hblank = 1'b1;
      tick();
    end
    pixel_valid = 1'b0;
    ppu_hblank  = 1'b0;
    tick();
    if (n > 0 && mdl_y < H) mdl_y++;
  endtask

  task automatic send_vblank();
    ppu_vblank = 1'b1;
    tick();
    ppu_vblank = 1'b0;
    tick();
    if (lcd_enable && mdl_y == H) begin
      disp      = build;
      mdl_front = ~mdl_front;
      mdl_blank = 1'b0;
    end
    mdl_y = 0;
  endtask

  task automatic test_reset();
    logic [1:0] d;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++; if (front_bank !== 1'b0) begin errors++; $display("FAIL reset_front got=%0d want=0", front_bank); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%0d want=0", frame_done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0d want=0", overflow); end
    checks++; if (rd_data !== 2'b00) begin errors++; $display("FAIL reset_rd_data got=%0d want=0", rd_data); end
    do_read(161, d);
    checks++; if (d !== 2'b00) begin errors++; $display("FAIL reset_read got=%0d want=0", d); end
  endtask

  task automatic test_short_frame();
    logic [1:0] d;
    int fd0 = fd_cnt;
    for (int l = 0; l < 100; l++) send_line(W, 1'b1);
    send_vblank();
    checks++; if (fd_cnt != fd0) begin errors++; $display("FAIL short_frame_done got=%0d want=0 pulses", fd_cnt - fd0); end
    checks++; if (front_bank !== mdl_front) begin errors++; $display("FAIL short_front got=%0d want=%0d", front_bank, mdl_front); end
    do_read(161, d);
    checks++; if (d !== exp_rd(161)) begin errors++; $display("FAIL short_read got=%0d want=%0d", d, exp_rd(161)); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL short_overflow got=%0d want=0", overflow); end
  endtask

  task automatic test_empty_line();
    send_line(0, 1'b0);
    checks++; if (overflow !== mdl_ovf) begin errors++; $display("FAIL empty_overflow got=%0d want=%0d", overflow, mdl_ovf); end
  endtask

  task automatic test_overlong_line();
    send_line(165, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overlong_overflow got=%0d want=1", overflow); end
  endtask

  task automatic test_full_frame();
    logic [1:0] d;
    int a;
    int fd0;
    for (int l = 1; l < H; l++) send_line(W, 1'b0);
    fd0 = fd_cnt;
    send_vblank();
    checks++; if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL full_frame_done got=%0d want=1 pulses", fd_cnt - fd0); end
    checks++; if (front_bank !== 1'b1) begin errors++; $display("FAIL full_front got=%0d want=1", front_bank); end
    do_read(161, d);
    checks++; if (d !== 2'd1) begin errors++; $display("FAIL full_read161 got=%0d want=1", d); end
    for (int x = 0; x < 165; x++) begin
      do_read(x, d);
      checks++; if (d !== exp_rd(x)) begin errors++; $display("FAIL line0_read addr=%0d got=%0d want=%0d", x, d, exp_rd(x)); end
    end
    for (int i = 0; i < 16; i++) begin
      a = $urandom_range(N - 1, 0);
      do_read(a, d);
      checks++; if (d !== exp_rd(a)) begin errors++; $display("FAIL full_rand_read addr=%0d got=%0d want=%0d", a, d, exp_rd(a)); end
    end
  endtask

  task automatic test_swap_simultaneous();
    logic [1:0] d, want_old;
    int a, b;
    for (int l = 0; l < H; l++) send_line(W, 1'b1);
    a = $urandom_range(N - 1, 0);
    b = $urandom_range(N - 1, 0);
    want_old = exp_rd(a);
    ppu_vblank = 1'b1;
    ppu_hblank = 1'b1;
    rd_addr    = 15'(a);
    rd_enable  = 1'b1;
    tick();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL swap_pulse got=%0d want=1", frame_done); end
    checks++; if (front_bank !== ~mdl_front) begin errors++; $display("FAIL swap_front got=%0d want=%0d", front_bank, ~mdl_front); end
    checks++; if (rd_data !== want_old) begin errors++; $display("FAIL swap_cycle_read addr=%0d got=%0d want=%0d", a, rd_data, want_old); end
    disp      = build;
    mdl_front = ~mdl_front;
    mdl_blank = 1'b0;
    mdl_y     = 0;
    rd_addr    = 15'(b);
    ppu_hblank = 1'b0;
    ppu_vblank = 1'b0;
    tick();
    rd_enable = 1'b0;
    checks++; if (rd_data !== exp_rd(b)) begin errors++; $display("FAIL post_swap_read addr=%0d got=%0d want=%0d", b, rd_data, exp_rd(b)); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL swap_pulse_width got=%0d want=0", frame_done); end
    for (int i = 0; i < 16; i++) begin
      a = $urandom_range(N - 1, 0);
      do_read(a, d);
      checks++; if (d !== exp_rd(a)) begin errors++; $display("FAIL swap_rand_read addr=%0d got=%0d want=%0d", a, d, exp_rd(a)); end
    end
  endtask

  task automatic test_lcd_disable();
    logic [1:0] d;
    int a, fd0;
    for (int l = 0; l < 10; l++) send_line(W, 1'b1);
    lcd_enable = 1'b0;
    tick();
    mdl_ovf = 1'b0; mdl_blank = 1'b1; mdl_y = 0;
    checks++; if (overflow !== mdl_ovf) begin errors++; $display("FAIL lcd_off_overflow got=%0d want=0", overflow); end
    a = $urandom_range(N - 1, 0);
    do_read(a, d);
    checks++; if (d !== 2'b00) begin errors++; $display("FAIL lcd_off_read got=%0d want=0", d); end
    fd0 = fd_cnt;
    send_vblank();
    checks++; if (fd_cnt != fd0) begin errors++; $display("FAIL lcd_off_swap got=%0d want=0 pulses", fd_cnt - fd0); end
    checks++; if (front_bank !== mdl_front) begin errors++; $display("FAIL lcd_off_front got=%0d want=%0d", front_bank, mdl_front); end
    lcd_enable = 1'b1;
    tick();
    for (int l = 0; l < H; l++) send_line(W, 1'b1);
    do_read(a, d);
    checks++; if (d !== 2'b00) begin errors++; $display("FAIL lcd_reen_blank_read got=%0d want=0", d); end
    fd0 = fd_cnt;
    send_vblank();
    checks++; if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL lcd_reen_done got=%0d want=1 pulses", fd_cnt - fd0); end
    checks++; if (front_bank !== mdl_front) begin errors++; $display("FAIL lcd_reen_front got=%0d want=%0d", front_bank, mdl_front); end
    for (int i = 0; i < 16; i++) begin
      a = $urandom_range(N - 1, 0);
      do_read(a, d);
      checks++; if (d !== exp_rd(a)) begin errors++; $display("FAIL lcd_reen_read addr=%0d got=%0d want=%0d", a, d, exp_rd(a)); end
    end
  endtask

  task automatic test_read_port();
    logic [1:0] d;
    int a;
    do_read(N, d);
    checks++; if (d !== 2'b00) begin errors++; $display("FAIL oor_read addr=%0d got=%0d want=0", N, d); end
    do_read(32767, d);
    checks++; if (d !== 2'b00) begin errors++; $display("FAIL oor_read addr=32767 got=%0d want=0", d); end
    a = $urandom_range(N - 1, 0);
    do_read(a, d);
    rd_addr = 15'((a + 1) % N);
    tick();
    tick();
    checks++; if (rd_data !== exp_rd(a)) begin errors++; $display("FAIL read_hold got=%0d want=%0d", rd_data, exp_rd(a)); end
  endtask

  task automatic test_reset_mid_frame();
    logic [1:0] d;
    for (int l = 0; l < 5; l++) send_line(W, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    mdl_blank = 1'b1; mdl_front = 1'b0; mdl_y = 0; mdl_ovf = 1'b0;
    checks++; if (front_bank !== 1'b0) begin errors++; $display("FAIL midreset_front got=%0d want=0", front_bank); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midreset_overflow got=%0d want=0", overflow); end
    do_read(161, d);
    checks++; if (d !== 2'b00) begin errors++; $display("FAIL midreset_read got=%0d want=0", d); end
  endtask

  initial begin
    test_reset();
    test_short_frame();
    test_empty_line();
    test_overlong_line();
    test_full_frame();
    test_swap_simultaneous();
    test_lcd_disable();
    test_read_port();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ppu_framebuffer.md
Name: ppu_framebuffer

Overview:
Downstream stage of the PPU. Consumes the PPU pixel stream (2-bit shade, valid strobe, hblank/vblank flags) and writes pixels into a double-buffered 160x144 frame store. A synchronous random-access read port serves the video output scanner. Banks swap only at frame boundaries, so the scanner never sees a torn frame.

Parameters:
WIDTH, 160, visible pixels per line
HEIGHT, 144, visible lines per frame
ADDR_W, 15, frame-store address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT

Ports:
clk  in  1  clock (4 MHz PPU clock)
reset  in  1  synchronous, active-high
lcd_enable  in  1  LCDC.7 from the PPU; 0 means LCD off
pixel_in  in  2  pixel shade from the PPU
pixel_valid  in  1  pixel_in is valid this cycle
ppu_hblank  in  1  PPU is in HBlank
ppu_vblank  in  1  PPU is in VBlank
rd_addr  in  ADDR_W  scanner read address, equal to y*WIDTH+x
rd_enable  in  1  scanner read strobe
rd_data  out  2  shade from the front bank, valid 1 cycle after rd_enable
frame_done  out  1  1-cycle pulse when the banks swap
front_bank  out  1  index of the bank currently readable
overflow  out  1  sticky flag: a pixel was dropped (x>=WIDTH or y>=HEIGHT); cleared by reset or an lcd_enable falling edge

Behaviour:
- Reset values: wr_x=0, wr_y=0, wr_addr=0, back bank=1, front_bank=0, rd_data=0, frame_done=0, overflow=0, blank=1. Frame-store contents are not reset.
- Edge detection: ppu_hblank and ppu_vblank are registered each cycle. hb_rise and vb_rise are computed from the current input and its registered copy.
- Write FSM has 3 states:
  - DRAW: pixels accepted.
  - LINE_END: waiting for hblank to drop.
  - FRAME_END: waiting for vblank to drop.
- Accepting a pixel (DRAW, pixel_valid=1, lcd_enable=1, wr_x<WIDTH, wr_y<HEIGHT):
  - Write pixel_in to the back bank at wr_addr.
  - wr_x++ and wr_addr++.
  - A pixel_valid outside these conditions sets overflow and writes nothing.
- Line end:
  - DRAW with hb_rise: if wr_x!=0 then wr_y++ and wr_addr = line_base+WIDTH; line_base takes the same value. Clear wr_x. Go to LINE_END.
  - If wr_x==0 (empty line), wr_y is unchanged.
  - LINE_END returns to DRAW when ppu_hblank==0.
- Frame end:
  - On vb_rise from any state: if wr_y==HEIGHT, swap banks (front_bank <= ~front_bank), pulse frame_done for 1 cycle, and clear blank.
  - If wr_y!=HEIGHT (short frame), do not swap; discard the partial frame.
  - In both cases clear wr_x, wr_y, wr_addr and line_base, then go to FRAME_END.
  - FRAME_END returns to DRAW when ppu_vblank==0.
- Simultaneous hb_rise and vb_rise: vb_rise wins. The line increment is applied first, so a full 144th line still counts toward wr_y==HEIGHT.
- Same-cycle pixel_valid with hb_rise: the pixel is accepted first (if legal), then the line-end update applies to the post-increment wr_x.
- lcd_enable=0:
  - Counters are held at 0 and the FSM is forced to FRAME_END.
  - blank=1, and rd_data reads 0 while blank=1.
  - No swap occurs.
  - On the falling edge of lcd_enable, clear overflow.
  - After re-enable, blank stays 1 until the first completed frame swaps.
- Read port:
  - Registered, 1-cycle latency; data is taken from the front bank.
  - rd_enable=0 holds rd_data.
  - rd_addr >= WIDTH*HEIGHT returns 0.
  - A read issued in the swap cycle returns data from the old front bank; the new bank takes effect from the next cycle.
- Reset mid-frame: all counters cleared, front_bank=0, blank=1; the partial frame is discarded.
- Storage: two banks of WIDTH*HEIGHT x 2 bits, each with 1 write and 1 read port. The write side always targets ~front_bank and the read side front_bank, so the two sides never collide.

Decomposition:
- Shared package ppu_pkg holds:
  - constants LCD_WIDTH=160 and LCD_HEIGHT=144;
  - typedef shade_t (logic [1:0]);
  - typedef fb_wr_state_e {FbDraw, FbLineEnd, FbFrameEnd}.
- ppu_mode_e also moves into ppu_pkg.
- One sub-module: fb_bank_ram, a simple dual-port RAM (sync write, registered read), instantiated twice.

Test Plan:
1. Full frame: 144 lines of 160 pixels with shade = x[1:0], each line followed by hblank, then vblank -> frame_done pulses once and front_bank=1. A read at addr 161 returns 1 one cycle later, and blank=0.
2. Short frame: only 100 lines, then vblank -> no frame_done, front_bank stays 0, and rd_data reads 0 (blank still set).
3. Overlong line: 165 valid pixels in a line -> pixels 160..164 are dropped, overflow=1, and the next line starts at addr 160.
4. Empty hblank (no pixels) followed by a hblank with 160 pixels -> wr_y advances only once, and the second line's data lands at addr 0..159.
5. Simultaneous events: the 144th line's last pixel and hblank rise in one cycle, then vblank rises on the same cycle as a later hblank -> swap occurs. A read in the swap cycle returns old-bank data; the next read returns new-bank data.
6. lcd_enable drops mid-frame, then re-enables and one full frame is sent -> no swap while disabled, overflow cleared, rd_data=0 until the first frame_done after re-enable.
